// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command receiver: FSM state encodings
// and parameter defaults used by uart_rx_byte and uart_cmd_rx.
package uart_cmd_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} pair_state_t;

    localparam int unsigned BAUD_DIV_DEFAULT    = 2604;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 1_000_000;

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Serial line plus command handshake between the UART command receiver (slave)
// and whatever drives RX and consumes commands (master).
interface uart_cmd_rx_if;

    logic        RX;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    modport master (
        output RX,
        output clr_cmd_rdy,
        input  cmd,
        input  cmd_rdy,
        input  frm_err
    );

    modport slave (
        input  RX,
        input  clr_cmd_rdy,
        output cmd,
        output cmd_rdy,
        output frm_err
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop RX synchronizer, mid-bit sampling FSM, and
// one-cycle byte_vld / frm_err pulses.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frm_err_o
);

    localparam int unsigned      CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(BAUD_DIV);

    rx_state_t        state_q;
    logic             sync1_q;
    logic             rxs_q;
    logic             rxs_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             byte_vld_q;
    logic             frm_err_q;
    logic             expire;

    // Counter is loaded with N and expires N cycles later, when it reaches 1.
    assign expire = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            sync1_q    <= rx_i;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            if (state_q != IDLE && !expire) begin
                cnt_q <= cnt_q - 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rxs_prev_q && !rxs_q) begin
                        state_q <= START;
                        cnt_q   <= HALF;
                    end
                end
                START: begin
                    if (expire) begin
                        if (rxs_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            cnt_q   <= FULL;
                            bit_q   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (expire) begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        cnt_q   <= FULL;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (expire) begin
                        state_q <= IDLE;
                        if (rxs_q) begin
                            byte_q     <= shift_q;
                            byte_vld_q <= 1'b1;
                        end else begin
                            frm_err_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_o     = byte_q;
    assign byte_vld_o = byte_vld_q;
    assign frm_err_o  = frm_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Pairs received UART bytes into 16-bit commands with a cmd_rdy/clr_cmd_rdy handshake.
// Define UART_CMD_TIMEOUT_EN to drop a lone high byte after TIMEOUT_CYC idle clocks.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned BAUD_DIV    = BAUD_DIV_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input logic          clk,
    input logic          rst_n,
    uart_cmd_rx_if.slave bus
);

    logic [7:0]  rx_byte;
    logic        byte_vld;
    logic        frm_err;
    pair_state_t pair_q;
    logic [7:0]  hi_q;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic        done;
    logic        tmo_hit;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (bus.RX),
        .byte_o     (rx_byte),
        .byte_vld_o (byte_vld),
        .frm_err_o  (frm_err)
    );

    assign done = (pair_q == WAIT_LO) && byte_vld;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = (pair_q == WAIT_LO) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Held at zero in WAIT_HI so it starts from zero on every entry to WAIT_LO.
    always_ff @(posedge clk) begin
        if (!rst_n || pair_q == WAIT_HI) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_q    <= WAIT_HI;
            hi_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            case (pair_q)
                WAIT_HI: begin
                    if (byte_vld) begin
                        hi_q   <= rx_byte;
                        pair_q <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // A completing byte wins over a timeout on the same cycle.
                    if (byte_vld) begin
                        cmd_q  <= {hi_q, rx_byte};
                        pair_q <= WAIT_HI;
                    end else if (frm_err || tmo_hit) begin
                        pair_q <= WAIT_HI;
                    end
                end
                default: pair_q <= WAIT_HI;
            endcase
            if (done) begin
                cmd_rdy_q <= 1'b1;
            end else if (bus.clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
        end
    end

    assign bus.cmd     = cmd_q;
    assign bus.cmd_rdy = cmd_rdy_q;
    assign bus.frm_err = frm_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed scenarios plus randomized bytes
// checked against a byte-pairing reference model.
module tb_uart_cmd_rx;

    localparam int BAUD = 32;
    localparam int TMO  = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .BAUD_DIV    (BAUD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Output monitors, sampled on the inactive edge
    int          frm_cnt  = 0;
    int          rise_cnt = 0;
    int          run_len  = 0;
    int          last_len = 0;
    logic        prev_rdy = 1'b0;
    logic [15:0] rise_cmd = '0;

    always @(negedge clk) begin
        if (bus.frm_err === 1'b1) frm_cnt++;
        if (bus.cmd_rdy === 1'b1) begin
            if (!prev_rdy) begin
                rise_cnt++;
                rise_cmd = bus.cmd;
            end
            run_len++;
        end else if (prev_rdy) begin
            last_len = run_len;
            run_len  = 0;
        end
        prev_rdy = (bus.cmd_rdy === 1'b1);
    end

    // Reference model: bytes pair up high-then-low; a framing error drops a pending high byte
    logic [15:0] exp_cmd  = '0;
    bit          exp_rdy  = 1'b0;
    logic [7:0]  m_hi     = '0;
    bit          m_hi_vld = 1'b0;
    int          exp_frm  = 0;

    function automatic void model_rx(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_frm++;
            m_hi_vld = 1'b0;
        end else if (!m_hi_vld) begin
            m_hi     = b;
            m_hi_vld = 1'b1;
        end else begin
            exp_cmd  = {m_hi, b};
            exp_rdy  = 1'b1;
            m_hi_vld = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        exp_cmd  = '0;
        exp_rdy  = 1'b0;
        m_hi_vld = 1'b0;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_start_data(input logic [7:0] b);
        bus.RX = 1'b0;
        wait_cyc(BAUD);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            wait_cyc(BAUD);
        end
    endtask

    task automatic send_stop(input bit ok);
        bus.RX = ok;
        wait_cyc(BAUD);
        bus.RX = 1'b1;
        if (!ok) wait_cyc(2 * BAUD);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        send_start_data(b);
        send_stop(ok);
        model_rx(b, ok);
    endtask

    task automatic pulse_clr();
        bus.clr_cmd_rdy = 1'b1;
        wait_cyc(1);
        bus.clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(3);
        total++; if (bus.cmd !== 16'h0000) begin bad++; $display("FAIL reset_cmd got=%h exp=0000", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", bus.cmd_rdy); end
        total++; if (bus.frm_err !== 1'b0) begin bad++; $display("FAIL reset_frm got=%b exp=0", bus.frm_err); end
        rst_n = 1'b1;
        model_reset();
        wait_cyc(2 * BAUD);
    endtask

    task automatic test_back_to_back();
        int f0 = frm_cnt;
        int r0 = rise_cnt;
        send_byte(8'hA5, 1'b1);
        send_start_data(8'h3C);
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL b2b_early_rdy got=%b exp=0", bus.cmd_rdy); end
        send_stop(1'b1);
        model_rx(8'h3C, 1'b1);
        total++; if (bus.cmd !== 16'hA53C) begin bad++; $display("FAIL b2b_cmd got=%h exp=a53c", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy got=%b exp=1", bus.cmd_rdy); end
        total++; if (rise_cnt - r0 !== 1) begin bad++; $display("FAIL b2b_rises got=%0d exp=1", rise_cnt - r0); end
        total++; if (frm_cnt != f0) begin bad++; $display("FAIL b2b_frm got=%0d exp=%0d", frm_cnt, f0); end
    endtask

    task automatic test_clear();
        bus.clr_cmd_rdy = 1'b1;
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL clr_before_edge got=%b exp=1", bus.cmd_rdy); end
        wait_cyc(1);
        bus.clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL clr_rdy got=%b exp=0", bus.cmd_rdy); end
        wait_cyc(3);
        total++; if (bus.cmd !== 16'hA53C) begin bad++; $display("FAIL clr_cmd got=%h exp=a53c", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL clr_hold got=%b exp=0", bus.cmd_rdy); end
    endtask

    task automatic test_frame_err();
        int f0 = frm_cnt;
        int r0 = rise_cnt;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        total++; if (frm_cnt - f0 !== 1) begin bad++; $display("FAIL fe_pulses got=%0d exp=1", frm_cnt - f0); end
        total++; if (rise_cnt != r0) begin bad++; $display("FAIL fe_no_rdy got=%0d exp=%0d", rise_cnt, r0); end
        total++; if (bus.cmd !== 16'hA53C) begin bad++; $display("FAIL fe_cmd_kept got=%h exp=a53c", bus.cmd); end
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        total++; if (bus.cmd !== 16'h5678) begin bad++; $display("FAIL fe_next_cmd got=%h exp=5678", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL fe_next_rdy got=%b exp=1", bus.cmd_rdy); end
        pulse_clr();
    endtask

    task automatic test_false_start();
        int f0 = frm_cnt;
        int r0 = rise_cnt;
        bus.RX = 1'b0;
        wait_cyc(10);
        bus.RX = 1'b1;
        wait_cyc(3 * BAUD);
        total++; if (frm_cnt != f0) begin bad++; $display("FAIL fs_frm got=%0d exp=%0d", frm_cnt, f0); end
        total++; if (rise_cnt != r0) begin bad++; $display("FAIL fs_rdy got=%0d exp=%0d", rise_cnt, r0); end
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        total++; if (bus.cmd !== 16'h0102) begin bad++; $display("FAIL fs_cmd got=%h exp=0102", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL fs_rdy2 got=%b exp=1", bus.cmd_rdy); end
        pulse_clr();
    endtask

    task automatic test_set_wins();
        int r0 = rise_cnt;
        bus.clr_cmd_rdy = 1'b1;
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_cyc(4);
        bus.clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        total++; if (rise_cnt - r0 !== 1) begin bad++; $display("FAIL sw_rises got=%0d exp=1", rise_cnt - r0); end
        total++; if (rise_cmd !== 16'hFF00) begin bad++; $display("FAIL sw_rise_cmd got=%h exp=ff00", rise_cmd); end
        total++; if (last_len !== 1) begin bad++; $display("FAIL sw_rdy_width got=%0d exp=1", last_len); end
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL sw_rdy_end got=%b exp=0", bus.cmd_rdy); end
        total++; if (bus.cmd !== 16'hFF00) begin bad++; $display("FAIL sw_cmd got=%h exp=ff00", bus.cmd); end
    endtask

    task automatic test_random();
        int f0 = frm_cnt;
        int e0 = exp_frm;
        logic [7:0] b;
        bit ok;
        for (int it = 0; it < 24; it++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_byte(b, ok);
            total++; if (bus.cmd !== exp_cmd) begin bad++; $display("FAIL rnd_cmd[%0d] got=%h exp=%h", it, bus.cmd, exp_cmd); end
            total++; if (bus.cmd_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_rdy[%0d] got=%b exp=%b", it, bus.cmd_rdy, exp_rdy); end
            if (exp_rdy && ($urandom_range(0, 1) == 1)) pulse_clr();
            wait_cyc($urandom_range(0, 3 * BAUD));
        end
        total++; if (frm_cnt - f0 != exp_frm - e0) begin bad++; $display("FAIL rnd_frm got=%0d exp=%0d", frm_cnt - f0, exp_frm - e0); end
        if (exp_rdy) pulse_clr();
        if (m_hi_vld) begin
            send_byte(8'h5A, 1'b0);
        end
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_timeout();
        send_byte(8'hAA, 1'b1);
        wait_cyc(2000);
        m_hi_vld = 1'b0;
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        total++; if (bus.cmd !== 16'hBBCC) begin bad++; $display("FAIL tmo_cmd got=%h exp=bbcc", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL tmo_rdy got=%b exp=1", bus.cmd_rdy); end
    endtask
`else
    task automatic test_timeout();
        send_byte(8'hAA, 1'b1);
        wait_cyc(2000);
        send_byte(8'hBB, 1'b1);
        total++; if (bus.cmd !== 16'hAABB) begin bad++; $display("FAIL notmo_cmd got=%h exp=aabb", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL notmo_rdy got=%b exp=1", bus.cmd_rdy); end
    endtask
`endif

    task automatic test_reset_mid();
        send_byte(8'h21, 1'b1);
        send_byte(8'h43, 1'b1);
        total++; if (bus.cmd !== exp_cmd) begin bad++; $display("FAIL rm_pre_cmd got=%h exp=%h", bus.cmd, exp_cmd); end
        send_byte(8'h11, 1'b1);
        fork
            send_start_data(8'hFF);
            begin
                wait_cyc(4 * BAUD);
                rst_n = 1'b0;
                wait_cyc(1);
                total++; if (bus.cmd !== 16'h0000) begin bad++; $display("FAIL rm_cmd got=%h exp=0000", bus.cmd); end
                total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL rm_rdy got=%b exp=0", bus.cmd_rdy); end
                rst_n = 1'b1;
            end
        join
        send_stop(1'b1);
        model_reset();
        wait_cyc(BAUD);
        send_byte(8'h9A, 1'b1);
        send_byte(8'hBC, 1'b1);
        total++; if (bus.cmd !== 16'h9ABC) begin bad++; $display("FAIL rm_after_cmd got=%h exp=9abc", bus.cmd); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL rm_after_rdy got=%b exp=1", bus.cmd_rdy); end
    endtask

    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bus.RX          = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        test_reset();
        test_back_to_back();
        test_clear();
        test_frame_err();
        test_false_start();
        test_set_wins();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
